acc_alu_seq: RTL and testbench
==============================

ACC_ALU_SEQ -- requirements
Module: acc_alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, AC/DR/result data width (>= 4).
REQ-002 Parameter MUL_EN, default 1; 1 = serial multiply implemented, 0 = MUL opcode decodes as NOP.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST_N  input  1  reset, synchronous, active-low.
REQ-005 OP_VALID  input  1  operation request strobe.
REQ-006 OP_READY  output  1  block can accept an operation this cycle.
REQ-007 OP  input  4  opcode, sampled on accept.
REQ-008 DR  input  WIDTH  data-register operand, sampled on accept.
REQ-009 AC  output  WIDTH  registered accumulator.
REQ-010 E  output  1  registered carry/extend flag.
REQ-011 DONE  output  1  one-cycle pulse: operation completed, AC/E final.
REQ-012 AC_ZERO  output  1  combinational (AC == 0).

Function
REQ-013 Accept = OP_VALID & OP_READY at a rising edge; OP and DR are ignored in all other cycles.
REQ-014 Opcodes: 0 NOP, 1 AND, 2 ADD, 3 LDA, 4 CMA, 5 CLA, 6 CLE, 7 CME, 8 CIR, 9 CIL, 10 INC, 11 MUL; 12-15 decode as NOP.
REQ-015 AND: AC <= AC & DR; E unchanged.
REQ-016 ADD: {E, AC} <= AC + DR, WIDTH+1-bit unsigned sum, carry into E.
REQ-017 LDA: AC <= DR. CMA: AC <= ~AC. CLA: AC <= 0. CLE: E <= 0. CME: E <= ~E; unlisted register unchanged.
REQ-018 CIR: {AC, E} <= {E, AC} (rotate right through E); CIL: {E, AC} <= {AC, E} (rotate left through E).
REQ-019 INC: AC <= AC + 1 modulo 2^WIDTH; E unchanged (all-ones wraps to 0).
REQ-020 Single-cycle ops (0-10, 12-15, and 11 when MUL_EN=0): AC/E update at the accept edge; DONE high for exactly the following cycle; OP_READY stays high, so back-to-back accepts every cycle are legal.
REQ-021 MUL (MUL_EN=1): unsigned AC x DR, shift-add, one multiplier bit per cycle, WIDTH cycles after accept.
REQ-022 MUL result: AC <= low WIDTH bits of product; E <= OR-reduce of high WIDTH bits (overflow flag).
REQ-023 FSM states IDLE, MUL_RUN: IDLE -> MUL_RUN on accept of MUL; MUL_RUN -> IDLE when bit counter reaches WIDTH-1; all other ops stay in IDLE.
REQ-024 OP_READY = 1 in IDLE, 0 in MUL_RUN; OP_VALID held during MUL_RUN is not accepted and has no effect.
REQ-025 During MUL_RUN, AC and E keep their pre-MUL values; final AC/E and the internal product are committed at the last MUL_RUN edge; DONE pulses the cycle after, coinciding with OP_READY returning high.
REQ-026 MUL operands are latched at accept; DR changes during MUL_RUN have no effect.

Reset
REQ-027 RST_N low at a rising edge: AC = 0, E = 0, DONE = 0, state = IDLE, bit counter and multiplier registers = 0; OP_READY = 1 from the first cycle after reset.
REQ-028 Reset mid-MUL aborts the operation: no DONE, no partial result written.
REQ-029 An accept coinciding with RST_N low is discarded.

Structure
REQ-030 Shared package acc_alu_pkg holds the opcode constants/enum and FSM state enum.
REQ-031 Serial multiplier datapath (partial product, multiplicand shift, counter) in one sub-module acc_alu_mul; top holds decode, AC/E registers, FSM, DONE.

Verification
REQ-032 WIDTH=8: LDA 0x3C then ADD 0xD0 back-to-back -> AC=0x0C, E=1, DONE high in each of the two cycles after the accepts.
REQ-033 AC=0x81, E=0: CIL -> AC=0x02, E=1; then CIR -> AC=0x81, E=0.
REQ-034 AC=0xFF, E=1: INC -> AC=0x00, E=1, AC_ZERO=1.
REQ-035 AC=0x0F, MUL DR=0x11 -> OP_READY low 8 cycles, then AC=0xFF, E=0, DONE 1 cycle; AC=0x10, MUL DR=0x10 -> AC=0x00, E=1, AC_ZERO=1.
REQ-036 OP_VALID=1 with OP=CLA held throughout a MUL -> CLA accepted only on the first cycle OP_READY=1; AC=0 the cycle after.
REQ-037 RST_N low at the 4th MUL_RUN cycle -> next cycle AC=0, E=0, OP_READY=1, DONE never pulses; MUL_EN=0 build: MUL -> AC unchanged, DONE after 1 cycle.

Source files
------------

// File: rtl/acc_alu_pkg.sv
// Shared opcode and FSM state definitions for the accumulator ALU.
package acc_alu_pkg;

   typedef enum logic [3:0] {
      OPC_NOP = 4'd0,
      OPC_AND = 4'd1,
      OPC_ADD = 4'd2,
      OPC_LDA = 4'd3,
      OPC_CMA = 4'd4,
      OPC_CLA = 4'd5,
      OPC_CLE = 4'd6,
      OPC_CME = 4'd7,
      OPC_CIR = 4'd8,
      OPC_CIL = 4'd9,
      OPC_INC = 4'd10,
      OPC_MUL = 4'd11
   } opcode_t;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_MUL_RUN = 1'b1
   } state_t;

endpackage

// File: rtl/acc_alu_mul.sv
// Serial shift-add multiplier: one multiplier bit per step, operands latched on start.
module acc_alu_mul
   import acc_alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               step,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               last,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      cnt;

   // product reflects the sum including the current step, so the top can commit it on the last edge
   assign product = prod + (mplier[0] ? mcand : '0);
   assign last    = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mcand  <= '0;
         prod   <= '0;
         mplier <= '0;
         cnt    <= '0;
      end else if (start) begin
         mcand  <= {{WIDTH{1'b0}}, a};
         prod   <= '0;
         mplier <= b;
         cnt    <= '0;
      end else if (step) begin
         mcand  <= mcand << 1;
         prod   <= product;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/acc_alu_seq.sv
// Accumulator ALU: single-cycle register ops on AC/E plus an optional serial multiply.
module acc_alu_seq
   import acc_alu_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int MUL_EN = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] dr,
   output logic [WIDTH-1:0] ac,
   output logic             e,
   output logic             done,
   output logic             ac_zero
);

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   ac_nxt;
   logic               e_nxt;
   logic               done_nxt;
   logic               mul_start;
   logic               mul_last;
   logic [2*WIDTH-1:0] mul_prod;

   assign op_ready = (state == ST_IDLE);
   assign ac_zero  = (ac == '0);

   acc_alu_mul #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .step    (state == ST_MUL_RUN),
      .a       (ac),
      .b       (dr),
      .last    (mul_last),
      .product (mul_prod)
   );

   always_comb begin
      state_nxt = state;
      ac_nxt    = ac;
      e_nxt     = e;
      done_nxt  = 1'b0;
      mul_start = 1'b0;
      case (state)
         ST_IDLE: begin
            if (op_valid) begin
               done_nxt = 1'b1;
               case (opcode_t'(op))
                  OPC_AND: ac_nxt = ac & dr;
                  OPC_ADD: {e_nxt, ac_nxt} = {1'b0, ac} + {1'b0, dr};
                  OPC_LDA: ac_nxt = dr;
                  OPC_CMA: ac_nxt = ~ac;
                  OPC_CLA: ac_nxt = '0;
                  OPC_CLE: e_nxt = 1'b0;
                  OPC_CME: e_nxt = ~e;
                  OPC_CIR: {ac_nxt, e_nxt} = {e, ac};
                  OPC_CIL: {e_nxt, ac_nxt} = {ac, e};
                  OPC_INC: ac_nxt = ac + 1'b1;
                  OPC_MUL: begin
                     // with the multiplier left out, MUL falls through as a NOP
                     if (MUL_EN != 0) begin
                        mul_start = 1'b1;
                        done_nxt  = 1'b0;
                        state_nxt = ST_MUL_RUN;
                     end
                  end
                  default: ;
               endcase
            end
         end
         ST_MUL_RUN: begin
            if (mul_last) begin
               ac_nxt    = mul_prod[WIDTH-1:0];
               e_nxt     = |mul_prod[2*WIDTH-1:WIDTH];
               done_nxt  = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         ac    <= '0;
         e     <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         ac    <= ac_nxt;
         e     <= e_nxt;
         done  <= done_nxt;
      end
   end

endmodule

// File: tb/tb_acc_alu_seq.sv
// Directed bench for acc_alu_seq: vector table of single-cycle ops plus multiply/reset sequences.
module tb_acc_alu_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       op_valid;
   logic [3:0] op;
   logic [7:0] dr;

   logic       op_ready, e, done, ac_zero;
   logic [7:0] ac;
   logic       nm_ready, nm_e, nm_done, nm_zero;
   logic [7:0] nm_ac;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [3:0] op;
      logic [7:0] dr;
      logic [7:0] exp_ac;
      logic       exp_e;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   acc_alu_seq #(.WIDTH(8), .MUL_EN(1)) dut (
      .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
      .op(op), .dr(dr), .ac(ac), .e(e), .done(done), .ac_zero(ac_zero)
   );

   acc_alu_seq #(.WIDTH(8), .MUL_EN(0)) dut_nomul (
      .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(nm_ready),
      .op(op), .dr(dr), .ac(nm_ac), .e(nm_e), .done(nm_done), .ac_zero(nm_zero)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] o, input logic [7:0] d);
      op_valid = 1'b1;
      op       = o;
      dr       = d;
      tick();
      op_valid = 1'b0;
   endtask

   task automatic doReset();
      rst_n    = 1'b0;
      op_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // accept MUL, check the 8 busy cycles, then the committed result
   task automatic mulSeq(input string tag, input logic [7:0] mdr, input logic [7:0] pre_ac,
                         input logic pre_e, input logic [7:0] exp_ac, input logic exp_e);
      applyStimulus(4'd11, mdr);
      dr = ~mdr;
      for (int i = 0; i < 8; i++) begin
         checkOutput({tag, " busy ready"}, op_ready, 0);
         checkOutput({tag, " busy ac"}, ac, pre_ac);
         checkOutput({tag, " busy e"}, e, pre_e);
         checkOutput({tag, " busy done"}, done, 0);
         tick();
      end
      checkOutput({tag, " ac"}, ac, exp_ac);
      checkOutput({tag, " e"}, e, exp_e);
      checkOutput({tag, " done"}, done, 1);
      checkOutput({tag, " ready"}, op_ready, 1);
      checkOutput({tag, " zero"}, ac_zero, exp_ac == 8'h00);
      tick();
      checkOutput({tag, " done drop"}, done, 0);
   endtask

   initial begin
      int done_seen;

      vecs.push_back('{4'd3,  8'h3C, 8'h3C, 1'b0});
      vecs.push_back('{4'd2,  8'hD0, 8'h0C, 1'b1});
      vecs.push_back('{4'd1,  8'h0A, 8'h08, 1'b1});
      vecs.push_back('{4'd4,  8'h00, 8'hF7, 1'b1});
      vecs.push_back('{4'd6,  8'h00, 8'hF7, 1'b0});
      vecs.push_back('{4'd7,  8'h00, 8'hF7, 1'b1});
      vecs.push_back('{4'd5,  8'h00, 8'h00, 1'b1});
      vecs.push_back('{4'd3,  8'h81, 8'h81, 1'b1});
      vecs.push_back('{4'd6,  8'h00, 8'h81, 1'b0});
      vecs.push_back('{4'd9,  8'h00, 8'h02, 1'b1});
      vecs.push_back('{4'd8,  8'h00, 8'h81, 1'b0});
      vecs.push_back('{4'd3,  8'hFF, 8'hFF, 1'b0});
      vecs.push_back('{4'd7,  8'h00, 8'hFF, 1'b1});
      vecs.push_back('{4'd10, 8'h00, 8'h00, 1'b1});
      vecs.push_back('{4'd0,  8'h55, 8'h00, 1'b1});
      vecs.push_back('{4'd13, 8'h55, 8'h00, 1'b1});
      vecs.push_back('{4'd2,  8'hFF, 8'hFF, 1'b0});
      vecs.push_back('{4'd2,  8'h01, 8'h00, 1'b1});

      op = 4'd0;
      dr = 8'h00;
      doReset();
      checkOutput("reset ac", ac, 0);
      checkOutput("reset e", e, 0);
      checkOutput("reset done", done, 0);
      checkOutput("reset ready", op_ready, 1);
      checkOutput("reset zero", ac_zero, 1);

      // back-to-back single-cycle ops
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].op, vecs[i].dr);
         checkOutput($sformatf("vec%0d ac", i), ac, vecs[i].exp_ac);
         checkOutput($sformatf("vec%0d e", i), e, vecs[i].exp_e);
         checkOutput($sformatf("vec%0d done", i), done, 1);
         checkOutput($sformatf("vec%0d ready", i), op_ready, 1);
         checkOutput($sformatf("vec%0d zero", i), ac_zero, vecs[i].exp_ac == 8'h00);
      end
      tick();
      checkOutput("idle done", done, 0);

      applyStimulus(4'd3, 8'h0F);
      mulSeq("mul 0F*11", 8'h11, 8'h0F, 1'b1, 8'hFF, 1'b0);
      applyStimulus(4'd3, 8'h10);
      mulSeq("mul 10*10", 8'h10, 8'h10, 1'b0, 8'h00, 1'b1);

      // CLA held valid throughout a multiply is taken only once ready returns
      applyStimulus(4'd3, 8'h33);
      applyStimulus(4'd11, 8'h02);
      op_valid = 1'b1;
      op       = 4'd5;
      for (int i = 0; i < 8; i++) begin
         checkOutput("hold busy ac", ac, 8'h33);
         tick();
      end
      checkOutput("hold mul ac", ac, 8'h66);
      checkOutput("hold mul done", done, 1);
      checkOutput("hold ready", op_ready, 1);
      tick();
      op_valid = 1'b0;
      checkOutput("hold cla ac", ac, 8'h00);
      checkOutput("hold cla done", done, 1);

      // reset during the 4th busy cycle aborts the multiply
      applyStimulus(4'd3, 8'h55);
      applyStimulus(4'd7, 8'h00);
      applyStimulus(4'd11, 8'h03);
      tick();
      tick();
      tick();
      rst_n    = 1'b0;
      op_valid = 1'b1;
      op       = 4'd3;
      dr       = 8'hAA;
      tick();
      op_valid = 1'b0;
      checkOutput("abort ac", ac, 0);
      checkOutput("abort e", e, 0);
      checkOutput("abort ready", op_ready, 1);
      checkOutput("abort done", done, 0);
      rst_n     = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 12; i++) begin
         if (done) done_seen++;
         tick();
      end
      checkOutput("abort no done", done_seen, 0);
      checkOutput("abort ac after", ac, 0);

      // MUL decodes as NOP when the multiplier is left out
      applyStimulus(4'd3, 8'h5A);
      applyStimulus(4'd11, 8'h03);
      checkOutput("nomul ac", nm_ac, 8'h5A);
      checkOutput("nomul e", nm_e, 0);
      checkOutput("nomul done", nm_done, 1);
      checkOutput("nomul ready", nm_ready, 1);
      tick();
      checkOutput("nomul done drop", nm_done, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
